// File: rtl/rf_writeback_ctrl.sv
// Writeback controller in front of the register file write port: ALU/LSU arbitration, strobed
// RF write sequencing and a pending-write scoreboard. Optional forwarding: RF_WB_FWD_EN.
module rf_writeback_ctrl #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_valid_i,
  output logic                 alu_ready_o,
  input  logic [4:0]           alu_waddr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_waddr_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 req_w_o,
  output logic [4:0]           waddr_o,
  output logic [DataWidth-1:0] wdata_alu_o,
  output logic [DataWidth-1:0] wdata_lsu_o,
  output logic                 soursel_o
`ifdef RF_WB_FWD_EN
  ,
  output logic                 fwd_a_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_b_data_o
`endif
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e      state_q;
  logic        last_alu_q;
  logic [31:0] busy_q;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic        grant_alu;
  logic        grant_lsu;
  logic        accept;
  logic [4:0]  acc_waddr;

  always_comb begin
    // On a tie the source that did not win last time gets the grant.
    grant_alu   = alu_valid_i && (!lsu_valid_i || !last_alu_q);
    grant_lsu   = lsu_valid_i && !grant_alu;
    alu_ready_o = (state_q == StIdle) && grant_alu;
    lsu_ready_o = (state_q == StIdle) && grant_lsu;
    accept      = alu_ready_o || lsu_ready_o;
    acc_waddr   = grant_alu ? alu_waddr_i : lsu_waddr_i;

    set_mask = '0;
    if (issue_valid_i && (issue_waddr_i != 5'd0)) begin
      set_mask[issue_waddr_i] = 1'b1;
    end
    clr_mask = '0;
    if (state_q == StStrobe) begin
      clr_mask[waddr_o] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      last_alu_q  <= 1'b0;
      busy_q      <= '0;
      req_w_o     <= 1'b0;
      waddr_o     <= '0;
      wdata_alu_o <= '0;
      wdata_lsu_o <= '0;
      soursel_o   <= 1'b0;
    end else begin
      // Set is applied after clear so a younger issue keeps ownership.
      busy_q <= (busy_q & ~clr_mask) | set_mask;
      case (state_q)
        StIdle: begin
          if (accept) begin
            last_alu_q <= alu_ready_o;
            // Writes to x0 complete the handshake but never reach the RF.
            if (acc_waddr != 5'd0) begin
              waddr_o   <= acc_waddr;
              soursel_o <= alu_ready_o;
              if (alu_ready_o) begin
                wdata_alu_o <= alu_wdata_i;
              end else begin
                wdata_lsu_o <= lsu_wdata_i;
              end
              state_q <= StSetup;
            end
          end
        end
        StSetup: begin
          req_w_o <= 1'b1;
          state_q <= StStrobe;
        end
        StStrobe: begin
          req_w_o <= 1'b0;
          state_q <= StHold;
        end
        StHold: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef RF_WB_FWD_EN
  logic                 younger_q;
  logic                 in_flight;
  logic [DataWidth-1:0] fwd_data;

  // Tracks whether a newer instruction re-claimed the destination after this write was accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      younger_q <= 1'b0;
    end else if (accept && (acc_waddr != 5'd0)) begin
      younger_q <= issue_valid_i && (issue_waddr_i == acc_waddr);
    end else if ((state_q != StIdle) && issue_valid_i && (issue_waddr_i == waddr_o)) begin
      younger_q <= 1'b1;
    end
  end

  always_comb begin
    in_flight     = (state_q != StIdle);
    fwd_data      = soursel_o ? wdata_alu_o : wdata_lsu_o;
    fwd_a_valid_o = in_flight && (raddr_a_i == waddr_o) && busy_q[waddr_o] && !younger_q;
    fwd_b_valid_o = in_flight && (raddr_b_i == waddr_o) && busy_q[waddr_o] && !younger_q;
    fwd_a_data_o  = fwd_data;
    fwd_b_data_o  = fwd_data;
    hazard_a_o    = busy_q[raddr_a_i] && !fwd_a_valid_o;
    hazard_b_o    = busy_q[raddr_b_i] && !fwd_b_valid_o;
  end
`else
  // busy_q[0] is never set, so x0 cannot report a hazard.
  always_comb begin
    hazard_a_o = busy_q[raddr_a_i];
    hazard_b_o = busy_q[raddr_b_i];
  end
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed steps then random traffic, checked every cycle against a
// timestamp-based transaction model.
module tb_rf_writeback_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic          alu_ready, lsu_ready, hazard_a, hazard_b, req_w, soursel;
  logic [4:0]    alu_waddr = '0, lsu_waddr = '0, issue_waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [4:0]    waddr;
  logic [DW-1:0] alu_wdata = '0, lsu_wdata = '0, wdata_alu, wdata_lsu;

  int checks = 0;
  int errors = 0;

  // Model: a non-x0 write accepted in cycle acc_cyc strobes in acc_cyc+2, frees at acc_cyc+4.
  int          cyc = 0;
  int          acc_cyc = -100;
  bit          last_was_alu = 1'b0;
  bit          busy [32];
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_alu = '0, m_lsu = '0;
  bit          m_sel = 1'b0;
  bit          acc_alu, acc_lsu;
  bit          order [$];

  rf_writeback_ctrl #(.DataWidth(DW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_waddr_i   (alu_waddr),
    .alu_wdata_i   (alu_wdata),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_waddr_i   (lsu_waddr),
    .lsu_wdata_i   (lsu_wdata),
    .issue_valid_i (issue_valid),
    .issue_waddr_i (issue_waddr),
    .raddr_a_i     (raddr_a),
    .raddr_b_i     (raddr_b),
    .hazard_a_o    (hazard_a),
    .hazard_b_o    (hazard_b),
    .req_w_o       (req_w),
    .waddr_o       (waddr),
    .wdata_alu_o   (wdata_alu),
    .wdata_lsu_o   (wdata_lsu),
    .soursel_o     (soursel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    bit         idle, ea, el, estr, ha, hb;
    logic [4:0] a;
    @(negedge clk);
    idle = (cyc - acc_cyc) >= 4;
    ea   = idle && alu_valid && (!lsu_valid || !last_was_alu);
    el   = idle && lsu_valid && (!alu_valid || last_was_alu);
    estr = (cyc == acc_cyc + 2);
    ha   = (raddr_a != 5'd0) && busy[raddr_a];
    hb   = (raddr_b != 5'd0) && busy[raddr_b];
    chk("alu_ready", 32'(alu_ready), 32'(ea));
    chk("lsu_ready", 32'(lsu_ready), 32'(el));
    chk("req_w", 32'(req_w), 32'(estr));
    chk("waddr", 32'(waddr), 32'(m_waddr));
    chk("wdata_alu", wdata_alu, m_alu);
    chk("wdata_lsu", wdata_lsu, m_lsu);
    chk("soursel", 32'(soursel), 32'(m_sel));
    chk("hazard_a", 32'(hazard_a), 32'(ha));
    chk("hazard_b", 32'(hazard_b), 32'(hb));
    @(posedge clk);
    if (estr) busy[m_waddr] = 1'b0;
    if (issue_valid && issue_waddr != 5'd0) busy[issue_waddr] = 1'b1;
    acc_alu = ea;
    acc_lsu = el;
    if (ea || el) begin
      last_was_alu = ea;
      a = ea ? alu_waddr : lsu_waddr;
      if (a != 5'd0) begin
        acc_cyc = cyc;
        m_waddr = a;
        m_sel   = ea;
        if (ea) m_alu = alu_wdata;
        else    m_lsu = lsu_wdata;
      end
    end
    cyc++;
    #1;
    if (acc_alu) alu_valid = 1'b0;
    if (acc_lsu) lsu_valid = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_req_w", 32'(req_w), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata_alu", wdata_alu, 32'd0);
    chk("rst_wdata_lsu", wdata_lsu, 32'd0);
    chk("rst_soursel", 32'(soursel), 32'd0);
    chk("rst_hazard_a", 32'(hazard_a), 32'd0);
    for (int i = 0; i < 32; i++) busy[i] = 1'b0;
    acc_cyc      = cyc - 100;
    last_was_alu = 1'b0;
    m_waddr      = '0;
    m_alu        = '0;
    m_lsu        = '0;
    m_sel        = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic alu_put(input logic [4:0] a, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_waddr = a;
    alu_wdata = d;
  endtask

  task automatic lsu_put(input logic [4:0] a, input logic [31:0] d);
    lsu_valid = 1'b1;
    lsu_waddr = a;
    lsu_wdata = d;
  endtask

  initial begin
    int na, nl, guard;
    do_reset();

    // Single ALU write to x5.
    alu_put(5'd5, 32'hDEADBEEF);
    tick();
    chk("t1_accepted", 32'(acc_alu), 32'd1);
    ticks(3);
    chk("t1_waddr", 32'(waddr), 32'd5);
    chk("t1_wdata", wdata_alu, 32'hDEADBEEF);
    tick();

    // Both sources contending: expect strict alternation starting with the ALU.
    do_reset();
    na = 0;
    nl = 0;
    guard = 0;
    alu_put(5'd1, $urandom);
    lsu_put(5'd2, $urandom);
    while ((na + nl) < 6 && guard < 40) begin
      tick();
      guard++;
      if (acc_alu) begin
        order.push_back(1'b1);
        na++;
        if (na < 3) alu_put(5'(1 + 2 * na), $urandom);
      end
      if (acc_lsu) begin
        order.push_back(1'b0);
        nl++;
        if (nl < 3) lsu_put(5'(2 + 2 * nl), $urandom);
      end
    end
    chk("rr_grants", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'((i % 2) == 0));
    ticks(4);

    // Scoreboard set by issue and cleared by writeback.
    issue_valid = 1'b1;
    issue_waddr = 5'd7;
    raddr_a     = 5'd7;
    tick();
    chk("t3_hazard_set", 32'(hazard_a), 32'd1);
    lsu_put(5'd7, 32'h0000_1234);
    ticks(5);
    chk("t3_hazard_clr", 32'(hazard_a), 32'd0);

    // Issue to x9 in the same cycle as its strobe: set wins.
    issue_valid = 1'b1;
    issue_waddr = 5'd9;
    raddr_b     = 5'd9;
    tick();
    alu_put(5'd9, 32'hCAFE_0009);
    ticks(2);
    issue_valid = 1'b1;
    issue_waddr = 5'd9;
    ticks(3);
    chk("t4_hazard_persists", 32'(hazard_b), 32'd1);

    // x0 write: handshake only; issue to x0 never raises a hazard.
    alu_put(5'd0, 32'h5555_AAAA);
    tick();
    chk("t5_x0_accepted", 32'(acc_alu), 32'd1);
    alu_put(5'd10, 32'h0000_000A);
    tick();
    chk("t5_ready_next", 32'(acc_alu), 32'd1);
    ticks(4);
    issue_valid = 1'b1;
    issue_waddr = 5'd0;
    raddr_a     = 5'd0;
    ticks(2);

    // Reset asserted while the strobe is high, then a normal write to x3.
    issue_valid = 1'b1;
    issue_waddr = 5'd3;
    raddr_a     = 5'd3;
    tick();
    alu_put(5'd3, 32'h3333_3333);
    ticks(2);
    chk("t6_strobe_high", 32'(req_w), 32'd1);
    do_reset();
    alu_put(5'd3, 32'h0303_0303);
    ticks(5);

    // Random traffic with protocol-compliant valid holding.
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid && $urandom_range(0, 2) == 0) alu_put(5'($urandom_range(0, 31)), $urandom);
      if (!lsu_valid && $urandom_range(0, 2) == 0) lsu_put(5'($urandom_range(0, 31)), $urandom);
      issue_valid = 1'($urandom_range(0, 1));
      issue_waddr = 5'($urandom_range(0, 31));
      raddr_a     = 5'($urandom_range(0, 31));
      raddr_b     = 5'($urandom_range(0, 31));
      tick();
    end
    guard = 0;
    while ((alu_valid || lsu_valid) && guard < 40) begin
      tick();
      guard++;
    end
    chk("drain_done", 32'(alu_valid || lsu_valid), 32'd0);
    ticks(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Writeback stage directly upstream of the register file write port.
- Accepts completed results from the ALU and LSU over valid/ready handshakes and arbitrates between them.
- Drives the RF edge-triggered write strobe (req_w), the write address, both data buses and the source select, with guaranteed setup and hold around the strobe.
- Keeps a 32-entry pending-write scoreboard so the operand-fetch stage can stall reads of registers still in flight.

Parameters:
DataWidth, 32, width of the result data buses.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
alu_valid_i  input  1  ALU result valid
alu_ready_o  output  1  ALU result accepted this cycle
alu_waddr_i  input  5  ALU destination register
alu_wdata_i  input  DataWidth  ALU result
lsu_valid_i  input  1  LSU load result valid
lsu_ready_o  output  1  LSU result accepted this cycle
lsu_waddr_i  input  5  LSU destination register
lsu_wdata_i  input  DataWidth  LSU load data
issue_valid_i  input  1  instruction with destination issued
issue_waddr_i  input  5  destination of the issued instruction
raddr_a_i  input  5  operand A address under query
raddr_b_i  input  5  operand B address under query
hazard_a_o  output  1  operand A register has a pending write
hazard_b_o  output  1  operand B register has a pending write
req_w_o  output  1  RF write strobe; RF writes on its rising edge
waddr_o  output  5  RF write address
wdata_alu_o  output  DataWidth  RF ALU data bus
wdata_lsu_o  output  DataWidth  RF LSU data bus
soursel_o  output  1  1 = ALU data, 0 = LSU data

Behaviour:
- Reset (async, rst_ni=0):
  - state IDLE; req_w_o, waddr_o, wdata_alu_o, wdata_lsu_o and soursel_o all 0.
  - busy[31:0]=0; last-grant pointer = LSU, so the ALU wins the first tie; hazards 0.
- FSM states and transitions:
  - IDLE: pick a source, accept it, go to SETUP.
  - SETUP: req_w_o=0 with address and data driven; go to STROBE.
  - STROBE: req_w_o=1; go to HOLD.
  - HOLD: req_w_o=0 with outputs still held; go to IDLE.
- Arbitration in IDLE:
  - One source valid: grant it.
  - Both valid: grant the source not granted last (round-robin).
  - x_ready_o=1 only in IDLE for the granted source (combinational from valid and state).
  - Transfer occurs when valid&&ready. Valid and payload must be held stable until accepted.
- On acceptance, captured into output registers:
  - waddr_o.
  - The selected data onto its own bus; the other bus keeps its previous value.
  - soursel_o (ALU=1).
- Outputs stay stable from SETUP through HOLD, and until the next acceptance.
- Timing:
  - Accept in cycle N, strobe high in cycle N+2, next accept possible in cycle N+4.
  - Peak throughput is 1 write per 4 cycles.
- Writes to x0:
  - Handshake completes and the FSM goes directly IDLE->IDLE.
  - No strobe, and the output registers are unchanged.
- Scoreboard:
  - issue_valid_i with issue_waddr_i!=0 sets busy[issue_waddr_i].
  - Leaving STROBE clears busy[waddr_o].
  - Set and clear of the same register in the same cycle: set wins, because the newer instruction owns the register.
  - Writeback to a register that is not busy is legal; clearing it is a no-op.
- Hazards:
  - hazard_a_o = busy[raddr_a_i] and hazard_b_o = busy[raddr_b_i], both combinational.
  - x0 never reports a hazard.
- Reset mid-write: all outputs clear immediately. A strobe that has already risen stays committed; no further edge is produced.
- No overflow conditions exist: the stage holds no queue beyond the single captured result.

Optional Feature:
RF_WB_FWD_EN
- Defined adds these ports:
  - fwd_a_valid_o 1 and fwd_a_data_o DataWidth.
  - fwd_b_valid_o 1 and fwd_b_data_o DataWidth.
- fwd_x_valid_o=1 when the state is SETUP, STROBE or HOLD, raddr_x_i==waddr_o, and that register's busy bit is set by this write only (no younger issue).
- fwd_x_data_o is the selected bus per soursel_o. hazard_x_o is suppressed in that case.
- Undefined: ports absent; hazards purely from busy.

Test Plan:
- Reset, then ALU valid waddr=5 data=0xDEADBEEF -> alu_ready_o=1 cycle N; req_w_o=1 only in N+2; waddr_o=5, wdata_alu_o=0xDEADBEEF, soursel_o=1 held N+1..N+3.
- ALU and LSU valid together for 3 writes each (regs 1..6) -> grant order ALU, LSU, ALU, LSU, ALU, LSU; soursel_o alternates 1,0; one strobe per 4 cycles.
- Issue waddr=7, raddr_a=7 -> hazard_a_o=1 next cycle; LSU writeback to 7 -> hazard_a_o=0 in the cycle after STROBE.
- Issue to 9 in the same cycle as STROBE for 9 -> busy[9] stays 1 and hazard persists.
- ALU write to x0 -> handshake completes, req_w_o never rises, ready returns the next cycle. Issue to x0 leaves hazard at 0.
- Drop rst_ni during STROBE -> req_w_o, waddr_o and busy cleared asynchronously; after release, a new ALU write to 3 completes normally.
